button_event_decoder: RTL and testbench

//  Turns the clean debounced level from the pushbutton debouncer into

---
 rtl/button_event_decoder_if.sv | 20 ++
 rtl/button_event_decoder.sv | 120 ++++++++++++
 tb/tb_button_event_decoder.sv | 108 ++++++++++
 3 files changed

// File: rtl/button_event_decoder_if.sv
// Button event bundle: debounced level in, single-cycle event pulses and held level out.
interface button_event_decoder_if;
    logic debounced;
    logic press;
    logic release_pulse;
    logic click;
    logic long_press;
    logic rpt;
    logic held;

    modport master (
        output debounced,
        input  press, release_pulse, click, long_press, rpt, held
    );

    modport slave (
        input  debounced,
        output press, release_pulse, click, long_press, rpt, held
    );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/click/long-press/auto-repeat
// pulses, all timed in clk_1KHz ticks.
module button_event_decoder #(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int CNT_W     = 16
) (
    input  logic                   clk_1KHz,
    input  logic                   rst,
    button_event_decoder_if.slave  bev
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] RPT_CNT  = CNT_W'(REPEAT_MS);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             prev_q_r;
    logic             press_r, press_s;
    logic             release_r, release_s;
    logic             click_r, click_s;
    logic             long_r, long_s;
    logic             rpt_r, rpt_s;
    logic             held_r, held_s;

    // State, counter, edge history and output pulse registers
    always_ff @(posedge clk_1KHz) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            prev_q_r  <= 1'b1;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            click_r   <= 1'b0;
            long_r    <= 1'b0;
            rpt_r     <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            prev_q_r  <= bev.debounced;
            press_r   <= press_s;
            release_r <= release_s;
            click_r   <= click_s;
            long_r    <= long_s;
            rpt_r     <= rpt_s;
            held_r    <= held_s;
        end
    end

    // Next-state, hold counter and pulse decode; release always beats a threshold
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        click_s   = 1'b0;
        long_s    = 1'b0;
        rpt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bev.debounced && !prev_q_r) begin
                    state_s = HOLD;
                    cnt_s   = CNT_ONE;
                    press_s = 1'b1;
                end else begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            HOLD: begin
                if (!bev.debounced) begin
                    state_s   = IDLE;
                    cnt_s     = CNT_ZERO;
                    release_s = 1'b1;
                    click_s   = 1'b1;
                end else if (cnt_r == LONG_CNT) begin
                    state_s = RPT;
                    cnt_s   = CNT_ONE;
                    long_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RPT: begin
                if (!bev.debounced) begin
                    state_s   = IDLE;
                    cnt_s     = CNT_ZERO;
                    release_s = 1'b1;
                end else if (cnt_r == RPT_CNT) begin
                    cnt_s = CNT_ONE;
                    rpt_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        held_s = (state_s != IDLE);
    end

    assign bev.press         = press_r;
    assign bev.release_pulse = release_r;
    assign bev.click         = click_r;
    assign bev.long_press    = long_r;
    assign bev.rpt           = rpt_r;
    assign bev.held          = held_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench: expected output vectors derived from the stimulus timeline
// are queued per edge and compared against the DUT one cycle later.
module tb_button_event_decoder;

    localparam int LONG = 10;
    localparam int REP  = 4;
    localparam int NE   = 130;
    localparam int NOCUT = 100000;

    localparam int B_PRESS = 0;
    localparam int B_REL   = 1;
    localparam int B_CLICK = 2;
    localparam int B_LONG  = 3;
    localparam int B_RPT   = 4;
    localparam int B_HELD  = 5;

    logic clk_1KHz = 1'b0;
    logic rst;

    button_event_decoder_if bev();

    button_event_decoder #(
        .LONG_MS   (LONG),
        .REPEAT_MS (REP),
        .CNT_W     (8)
    ) dut (
        .clk_1KHz (clk_1KHz),
        .rst      (rst),
        .bev      (bev)
    );

    always #5 clk_1KHz = ~clk_1KHz;

    logic       stim_deb [NE];
    logic       stim_rst [NE];
    logic [5:0] exp_vec  [NE];
    logic [5:0] sb_q     [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_out(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got {held,rpt,long,click,rel,press}=%b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic mark(input int e, input int b, input int cut);
        if (e < cut && e < NE) exp_vec[e][b] = 1'b1;
    endtask

    // Press starting at edge n, debounced high for len edges then low.
    // Expected events at or after edge cut are suppressed (reset mid-hold).
    task automatic add_press(input int n, input int len, input int cut);
        for (int e = n; e < n + len; e++) begin
            stim_deb[e] = 1'b1;
            mark(e, B_HELD, cut);
        end
        mark(n, B_PRESS, cut);
        if (len > LONG) begin
            mark(n + LONG, B_LONG, cut);
            for (int t = n + LONG + REP; t < n + len; t += REP) mark(t, B_RPT, cut);
        end
        mark(n + len, B_REL, cut);
        if (len <= LONG) mark(n + len, B_CLICK, cut);
    endtask

    logic [5:0] obs_v;
    logic [5:0] exp_pop;

    initial begin
        for (int e = 0; e < NE; e++) begin
            stim_deb[e] = 1'b0;
            stim_rst[e] = 1'b0;
            exp_vec[e]  = 6'b000000;
        end
        for (int e = 0; e < 3; e++) stim_rst[e] = 1'b1;

        add_press(5, 3, NOCUT);     // short click
        add_press(12, 1, NOCUT);    // 1,0,1 pattern: two presses back to back
        add_press(14, 1, NOCUT);
        add_press(20, 20, NOCUT);   // long press with two repeats
        add_press(45, 10, NOCUT);   // release on the threshold edge
        add_press(60, 11, NOCUT);   // long press reached, release before first repeat
        add_press(80, 20, 92);      // reset during repeat phase, still held after
        stim_rst[92] = 1'b1;
        for (int e = 105; e <= 110; e++) stim_deb[e] = 1'b1;  // held through reset
        stim_rst[105] = 1'b1;
        stim_rst[106] = 1'b1;
        add_press(115, 2, NOCUT);

        for (int e = 0; e < NE; e++) begin
            bev.debounced = stim_deb[e];
            rst           = stim_rst[e];
            sb_q.push_back(exp_vec[e]);
            @(posedge clk_1KHz);
            @(negedge clk_1KHz);
            obs_v   = {bev.held, bev.rpt, bev.long_press, bev.click, bev.release_pulse, bev.press};
            exp_pop = sb_q.pop_front();
            check_out($sformatf("edge%0d", e), obs_v, exp_pop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
